// File: rtl/traffic_conflict_monitor.sv
// Traffic light conflict monitor: passes controller light codes to the lamps
// with one cycle of latency, and latches a fail-safe flashing-red state on a
// conflict, invalid-encoding or yellow-timing violation.
module traffic_conflict_monitor #(
  parameter int YMIN        = 2,
  parameter int YMAX        = 5,
  parameter int FILT        = 2,
  parameter int STARTUP_CYC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_S,
  output logic [2:0] lamp_M1,
  output logic [2:0] lamp_M2,
  output logic [2:0] lamp_MT,
  output logic [2:0] lamp_S,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [3:0] fault_dir
);

  localparam logic [2:0] RED  = 3'b100;
  localparam logic [2:0] YEL  = 3'b010;
  localparam logic [2:0] GRN  = 3'b001;
  localparam logic [2:0] DARK = 3'b000;

  localparam int FW = $clog2(FILT + 1);
  localparam int SW = (STARTUP_CYC < 2) ? 1 : $clog2(STARTUP_CYC);
  localparam logic [FW-1:0] FILT_L     = FW'(FILT);
  localparam logic [SW-1:0] START_LAST = SW'(STARTUP_CYC - 1);
  localparam logic [2:0]    YMIN_L     = 3'(YMIN);
  localparam logic [3:0]    YLIM_L     = 4'(YMAX + 1);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [SW-1:0] start_cnt_reg;
  logic          det_reg;
  logic [1:0]    det_code_reg;
  logic [3:0]    det_dir_reg;
  logic          fault_reg;
  logic [1:0]    fault_code_reg;
  logic [3:0]    fault_dir_reg;

  // Direction order everywhere is {M1, M2, MT, S}, M1 in the top slot.
  logic [11:0] light_all;
  logic [11:0] lamp_all;
  logic [3:0]  open_w;
  logic [3:0]  enc_w;
  logic [3:0]  tim_w;

  logic       conf_s;
  logic       conf_mt;
  logic [3:0] conf_dir;
  logic [1:0] det_code_next;
  logic [3:0] det_dir_next;

  assign light_all = {light_M1, light_M2, light_MT, light_S};

  for (genvar gi = 0; gi < 4; gi++) begin : gen_dir
    logic [2:0]    code;
    logic          valid;
    logic [2:0]    lamp_reg;
    logic [2:0]    prev_reg;
    logic [2:0]    ycnt_reg;
    logic [FW-1:0] fcnt_reg;
    logic [2:0]    ycnt_inc;
    logic [FW-1:0] fcnt_inc;
    logic          tim_hit;

    assign code     = light_all[gi*3 +: 3];
    assign valid    = (code == RED) || (code == YEL) || (code == GRN);
    assign ycnt_inc = (ycnt_reg == 3'd7) ? ycnt_reg : ycnt_reg + 3'd1;
    assign fcnt_inc = (fcnt_reg == FILT_L) ? fcnt_reg : fcnt_reg + FW'(1);

    assign open_w[gi]            = valid && (code != RED);
    assign enc_w[gi]             = !valid && (fcnt_inc == FILT_L);
    assign tim_w[gi]             = tim_hit;
    assign lamp_all[gi*3 +: 3]   = lamp_reg;

    // Transition legality and yellow duration against the last valid code.
    always_comb begin
      tim_hit = 1'b0;
      if (valid) begin
        case (prev_reg)
          RED:     tim_hit = (code == YEL);
          GRN:     tim_hit = (code == RED);
          YEL:     tim_hit = (code == GRN) || ((code == RED) && (ycnt_reg < YMIN_L));
          default: tim_hit = 1'b0;
        endcase
        if ((code == YEL) && ({1'b0, ycnt_inc} >= YLIM_L)) begin
          tim_hit = 1'b1;
        end
      end
    end

    // Lamp drive and per-direction history; invalid samples freeze history.
    always_ff @(posedge clk) begin
      if (rst) begin
        lamp_reg <= RED;
        prev_reg <= RED;
        ycnt_reg <= 3'd0;
        fcnt_reg <= '0;
      end else begin
        case (state_reg)
          ST_MONITOR: begin
            if (det_reg) begin
              lamp_reg <= RED;
            end else if (valid) begin
              lamp_reg <= code;
              prev_reg <= code;
              ycnt_reg <= (code == YEL) ? ycnt_inc : 3'd0;
              fcnt_reg <= '0;
            end else begin
              fcnt_reg <= fcnt_inc;
            end
          end
          ST_FAULT: begin
            lamp_reg <= (lamp_reg == RED) ? DARK : RED;
          end
          default: begin
            lamp_reg <= RED;
            prev_reg <= RED;
            ycnt_reg <= 3'd0;
            fcnt_reg <= '0;
          end
        endcase
      end
    end
  end

  // Classify this cycle's sample; conflict outranks encoding outranks timing.
  always_comb begin
    conf_s   = open_w[0] && (open_w[3] || open_w[2] || open_w[1]);
    conf_mt  = open_w[1] && open_w[2];
    conf_dir = 4'b0000;
    if (conf_s) begin
      conf_dir = conf_dir | {open_w[3:1], 1'b1};
    end
    if (conf_mt) begin
      conf_dir = conf_dir | 4'b0110;
    end
    det_code_next = 2'b00;
    det_dir_next  = 4'b0000;
    if (conf_dir != 4'b0000) begin
      det_code_next = 2'b01;
      det_dir_next  = conf_dir;
    end else if (enc_w != 4'b0000) begin
      det_code_next = 2'b10;
      det_dir_next  = enc_w;
    end else if (tim_w != 4'b0000) begin
      det_code_next = 2'b11;
      det_dir_next  = tim_w;
    end
  end

  // Next-state: timed startup, monitor until a detection, fault until reset.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_STARTUP: if (start_cnt_reg == START_LAST) state_next = ST_MONITOR;
      ST_MONITOR: if (det_reg) state_next = ST_FAULT;
      ST_FAULT:   state_next = ST_FAULT;
      default:    state_next = ST_STARTUP;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_STARTUP;
    end else begin
      state_reg <= state_next;
    end
  end

  // Startup timer, one-cycle detection stage and latched fault report.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_cnt_reg  <= '0;
      det_reg        <= 1'b0;
      det_code_reg   <= 2'b00;
      det_dir_reg    <= 4'b0000;
      fault_reg      <= 1'b0;
      fault_code_reg <= 2'b00;
      fault_dir_reg  <= 4'b0000;
    end else begin
      case (state_reg)
        ST_STARTUP: begin
          start_cnt_reg <= start_cnt_reg + SW'(1);
          det_reg       <= 1'b0;
        end
        ST_MONITOR: begin
          if (det_reg) begin
            fault_reg      <= 1'b1;
            fault_code_reg <= det_code_reg;
            fault_dir_reg  <= det_dir_reg;
          end else begin
            det_reg      <= (det_code_next != 2'b00);
            det_code_reg <= det_code_next;
            det_dir_reg  <= det_dir_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign {lamp_M1, lamp_M2, lamp_MT, lamp_S} = lamp_all;
  assign fault      = fault_reg;
  assign fault_code = fault_code_reg;
  assign fault_dir  = fault_dir_reg;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: directed scenarios with literal
// expectations plus a randomized run compared every cycle to a rule model.
module tb_traffic_conflict_monitor;

  localparam int YMIN        = 2;
  localparam int YMAX        = 5;
  localparam int FILT        = 2;
  localparam int STARTUP_CYC = 3;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] X = 3'b011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] light_M1 = R, light_M2 = R, light_MT = R, light_S = R;
  logic [2:0] lamp_M1, lamp_M2, lamp_MT, lamp_S;
  logic       fault;
  logic [1:0] fault_code;
  logic [3:0] fault_dir;

  traffic_conflict_monitor #(
    .YMIN(YMIN), .YMAX(YMAX), .FILT(FILT), .STARTUP_CYC(STARTUP_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .light_M1(light_M1), .light_M2(light_M2), .light_MT(light_MT), .light_S(light_S),
    .lamp_M1(lamp_M1), .lamp_M2(lamp_M2), .lamp_MT(lamp_MT), .lamp_S(lamp_S),
    .fault(fault), .fault_code(fault_code), .fault_dir(fault_dir)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_checks = 0;

  // Rule model: index 3=M1, 2=M2, 1=MT, 0=S.
  int m_valid = 0;
  int m_phase = 0;          // 0 startup, 1 monitoring, 2 fault
  int m_st, m_fage;
  int m_last[4], m_yrun[4], m_bad[4], m_lamp[4];
  int m_pend, m_pcode, m_pdir;
  int m_fault, m_code, m_dir;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit is_valid(input int c);
    return (c == 4) || (c == 2) || (c == 1);
  endfunction

  function automatic bit legal_tr(input int a, input int b);
    return (a == b) || (a == 4 && b == 1) || (a == 1 && b == 2) || (a == 2 && b == 4);
  endfunction

  task automatic model_step();
    int c[4];
    int op[4];
    int conf, enc, tim;
    c[3] = int'(light_M1); c[2] = int'(light_M2); c[1] = int'(light_MT); c[0] = int'(light_S);
    if (rst) begin
      m_valid = 1; m_phase = 0; m_st = 0; m_fage = 0;
      m_pend = 0; m_pcode = 0; m_pdir = 0;
      m_fault = 0; m_code = 0; m_dir = 0;
      for (int d = 0; d < 4; d++) begin
        m_last[d] = 4; m_yrun[d] = 0; m_bad[d] = 0; m_lamp[d] = 4;
      end
    end else if (m_valid == 0) begin
      return;
    end else if (m_phase == 0) begin
      m_st++;
      for (int d = 0; d < 4; d++) m_lamp[d] = 4;
      if (m_st >= STARTUP_CYC) m_phase = 1;
    end else if (m_phase == 1) begin
      if (m_pend != 0) begin
        m_phase = 2; m_fage = 0;
        m_fault = 1; m_code = m_pcode; m_dir = m_pdir;
        for (int d = 0; d < 4; d++) m_lamp[d] = 4;
      end else begin
        conf = 0; enc = 0; tim = 0;
        for (int d = 0; d < 4; d++) begin
          op[d] = (is_valid(c[d]) && c[d] != 4) ? 1 : 0;
          if (is_valid(c[d])) begin
            m_bad[d] = 0;
            if (!legal_tr(m_last[d], c[d])) tim |= (1 << d);
            if (c[d] == 2) begin
              m_yrun[d]++;
              if (m_yrun[d] > YMAX) tim |= (1 << d);
            end else begin
              if (c[d] == 4 && m_last[d] == 2 && m_yrun[d] < YMIN) tim |= (1 << d);
              m_yrun[d] = 0;
            end
            m_last[d] = c[d];
            m_lamp[d] = c[d];
          end else begin
            m_bad[d]++;
            if (m_bad[d] >= FILT) enc |= (1 << d);
          end
        end
        if (op[0] == 1 && (op[3] + op[2] + op[1]) > 0)
          conf |= 1 | (op[3] << 3) | (op[2] << 2) | (op[1] << 1);
        if (op[1] == 1 && op[2] == 1) conf |= 6;
        if (conf != 0)      begin m_pend = 1; m_pcode = 1; m_pdir = conf; end
        else if (enc != 0)  begin m_pend = 1; m_pcode = 2; m_pdir = enc; end
        else if (tim != 0)  begin m_pend = 1; m_pcode = 3; m_pdir = tim; end
      end
    end else begin
      m_fage++;
      for (int d = 0; d < 4; d++) m_lamp[d] = (m_fage % 2 == 1) ? 0 : 4;
    end
  endtask

  // Apply one sample across a rising edge; returns at the following falling edge.
  task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input logic [2:0] d);
    light_M1 = a; light_M2 = b; light_MT = c; light_S = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(R, R, R, R);
    rst = 1'b0;
    repeat (STARTUP_CYC) drive(R, R, R, R);
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_valid != 0) begin
      check("lamp_M1", int'(lamp_M1), m_lamp[3]);
      check("lamp_M2", int'(lamp_M2), m_lamp[2]);
      check("lamp_MT", int'(lamp_MT), m_lamp[1]);
      check("lamp_S", int'(lamp_S), m_lamp[0]);
      check("fault", int'(fault), m_fault);
      check("fault_code", int'(fault_code), m_code);
      check("fault_dir", int'(fault_dir), m_dir);
    end
  end

  int cur[4];
  int r;

  initial begin
    @(negedge clk);
    // Reset values and startup hold.
    rst = 1'b1;
    drive(R, R, R, R);
    check("rst_fault", int'(fault), 0);
    check("rst_code", int'(fault_code), 0);
    check("rst_dir", int'(fault_dir), 0);
    check("rst_lamp_S", int'(lamp_S), 4);
    rst = 1'b0;
    repeat (STARTUP_CYC) begin
      drive(G, R, R, R);
      check("startup_hold", int'(lamp_M1), 4);
    end
    drive(G, R, R, R);
    check("track_M1", int'(lamp_M1), 1);
    check("model_track", m_lamp[3], 1);

    // Legal green/yellow/red cycle, then a short yellow.
    repeat (3) drive(G, R, R, R);
    repeat (2) drive(Y, R, R, R);
    drive(R, R, R, R);
    check("yel2_fault", int'(fault), 0);
    check("yel2_lamp", int'(lamp_M1), 4);
    drive(R, R, R, R);
    check("yel2_after", int'(fault), 0);
    repeat (2) drive(G, R, R, R);
    drive(Y, R, R, R);
    drive(R, R, R, R);
    check("yel1_pending", int'(fault), 0);
    drive(R, R, R, R);
    check("yel1_fault", int'(fault), 1);
    check("yel1_code", int'(fault_code), 3);
    check("yel1_dir", int'(fault_dir), 8);
    check("model_yel1_code", m_code, 3);
    drive(G, G, G, G);
    check("blink_dark", int'(lamp_M1), 0);
    drive(G, G, G, G);
    check("blink_red", int'(lamp_S), 4);

    // Reset out of FAULT, then normal tracking after startup.
    rst = 1'b1;
    drive(R, R, R, R);
    check("refault_rst_fault", int'(fault), 0);
    check("refault_rst_code", int'(fault_code), 0);
    check("refault_rst_dir", int'(fault_dir), 0);
    rst = 1'b0;
    repeat (STARTUP_CYC) begin
      drive(G, R, R, R);
      check("restart_hold", int'(lamp_M1), 4);
    end
    drive(G, R, R, R);
    check("restart_track", int'(lamp_M1), 1);

    // S with M2 open.
    do_reset();
    drive(R, G, R, G);
    check("conf_pending", int'(fault), 0);
    drive(R, G, R, G);
    check("conf_fault", int'(fault), 1);
    check("conf_code", int'(fault_code), 1);
    check("conf_dir", int'(fault_dir), 5);
    check("conf_lamp_red", int'(lamp_M2), 4);
    drive(R, R, R, R);
    check("conf_lamp_dark", int'(lamp_M2), 0);

    // M1 with MT is legal.
    do_reset();
    repeat (3) drive(G, R, G, R);
    check("m1_mt_ok", int'(fault), 0);

    // Encoding glitch filter.
    do_reset();
    drive(R, R, X, R);
    check("glitch_hold", int'(lamp_MT), 4);
    drive(R, R, G, R);
    check("glitch_recover", int'(lamp_MT), 1);
    drive(R, R, G, R);
    check("glitch_nofault", int'(fault), 0);
    drive(R, R, X, R);
    check("enc_hold_green", int'(lamp_MT), 1);
    drive(R, R, X, R);
    drive(R, R, G, R);
    check("enc_code", int'(fault_code), 2);
    check("enc_dir", int'(fault_dir), 2);
    check("model_enc_code", m_code, 2);

    // Simultaneous conflict and encoding: conflict reported alone.
    do_reset();
    drive(R, X, R, R);
    drive(G, X, R, G);
    drive(R, R, R, R);
    check("prio_code", int'(fault_code), 1);
    check("prio_dir", int'(fault_dir), 9);

    // Filter count discarded by reset.
    do_reset();
    drive(R, R, R, X);
    do_reset();
    drive(R, R, R, X);
    drive(R, R, R, R);
    drive(R, R, R, R);
    check("filt_rst_nofault", int'(fault), 0);

    // Longest legal yellow, then one beyond.
    do_reset();
    drive(G, R, R, R);
    repeat (YMAX) drive(Y, R, R, R);
    drive(R, R, R, R);
    drive(R, R, R, R);
    check("ymax_ok", int'(fault), 0);
    drive(G, R, R, R);
    repeat (YMAX + 1) drive(Y, R, R, R);
    check("ymax_pending", int'(fault), 0);
    drive(Y, R, R, R);
    check("ymax_fault", int'(fault), 1);
    check("ymax_code", int'(fault_code), 3);
    check("ymax_dir", int'(fault_dir), 8);

    // Randomized traffic with occasional corruption and resets.
    for (int d = 0; d < 4; d++) cur[d] = 4;
    for (int k = 0; k < 3000; k++) begin
      if (m_phase == 2 && m_fage >= 3) rst = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      else rst = 1'b0;
      for (int d = 0; d < 4; d++) begin
        r = int'($urandom_range(0, 99));
        if (r >= 97) begin
          cur[d] = int'($urandom_range(0, 7));
        end else if (r >= ((d == 0) ? 90 : 70)) begin
          if (!is_valid(cur[d])) cur[d] = 4;
          else if (cur[d] == 4) cur[d] = 1;
          else if (cur[d] == 1) cur[d] = 2;
          else cur[d] = 4;
        end
      end
      drive(3'(cur[3]), 3'(cur[2]), 3'(cur[1]), 3'(cur[0]));
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_conflict_monitor.md
TRAFFIC_CONFLICT_MONITOR -- requirements
Module: traffic_conflict_monitor

Interface
REQ-001 Parameter YMIN, default 2, minimum legal consecutive yellow cycles per direction.
REQ-002 Parameter YMAX, default 5, maximum legal consecutive yellow cycles per direction.
REQ-003 Parameter FILT, default 2, consecutive invalid-encoding cycles before an encoding fault.
REQ-004 Parameter STARTUP_CYC, default 3, all-red hold cycles after reset.
REQ-005 clk  input  1  single clock, rising-edge, 1 Hz nominal.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 light_M1, light_M2, light_MT, light_S  input  3 each  controller light codes: bit2=red, bit1=yellow, bit0=green.
REQ-008 lamp_M1, lamp_M2, lamp_MT, lamp_S  output  3 each  registered lamp drive, same encoding.
REQ-009 fault  output  1  latched fail-safe indication.
REQ-010 fault_code  output  2  00 none, 01 conflict, 10 encoding, 11 timing.
REQ-011 fault_dir  output  4  {M1,M2,MT,S} directions implicated in the latched fault.

Function
REQ-012 Valid codes SHALL be exactly 3'b100, 3'b010, 3'b001; a direction is "open" when its valid code is not red.
REQ-013 States SHALL be STARTUP, MONITOR, FAULT; STARTUP -> MONITOR after STARTUP_CYC cycles; MONITOR -> FAULT on any fault; FAULT exits only via rst.
REQ-014 STARTUP: all lamps 3'b100, no checks performed, prev-code registers loaded with red.
REQ-015 MONITOR: each lamp SHALL equal its input sampled on the previous edge (latency 1 cycle).
REQ-016 Conflict: S open while any of M1, M2, MT open, or MT open while M2 open; M1 with MT is legal.
REQ-017 Encoding: any input invalid for FILT consecutive cycles; per-direction counter resets on a valid sample; a 1-cycle glitch (FILT=2) SHALL NOT fault.
REQ-018 During an invalid cycle the direction's lamp SHALL hold its previous value, prev-code and yellow counter SHALL hold, and transition checks SHALL be skipped.
REQ-019 Legal transitions on valid codes: red->red, red->green, green->green, green->yellow, yellow->yellow, yellow->red; any other is a timing fault.
REQ-020 Yellow counter per direction (3 bits, saturating at 7) counts consecutive yellow samples; yellow->red with count < YMIN, or count reaching YMAX+1 while yellow, is a timing fault.
REQ-021 Detection on the sample at edge n SHALL set fault, fault_code, fault_dir and enter FAULT at edge n+1; FAULT lamp output takes effect the same edge.
REQ-022 Simultaneous faults: fault_code priority conflict > encoding > timing; fault_dir SHALL OR all directions implicated by the reported fault class only.
REQ-023 FAULT: all lamps SHALL toggle between 3'b100 and 3'b000 each cycle, starting with 3'b100; inputs ignored; code and dir frozen.

Reset
REQ-024 rst high at an edge SHALL force STARTUP, lamps 3'b100, fault 0, fault_code 00, fault_dir 0000, all counters 0, prev-codes red, from any state including FAULT.
REQ-025 rst asserted mid-yellow or mid-filter SHALL discard partial counts; STARTUP_CYC counting begins on the first edge with rst low.

Verification
REQ-026 Release rst, inputs all 3'b100 -> lamps 3'b100 for 3 cycles, then track inputs with 1-cycle latency, fault 0.
REQ-027 M1 green 4 cycles, yellow 2 cycles, red -> no fault; repeat with yellow 1 cycle -> fault=1, code 11, dir 1000 one cycle after the red sample.
REQ-028 S=3'b001 while M2=3'b001 -> next edge fault=1, code 01, dir 0101; lamps 100,000,100,... thereafter.
REQ-029 MT=3'b011 for 1 cycle then 3'b001 -> no fault, lamp_MT holds prior value that cycle; 3'b011 for 2 cycles -> code 10, dir 0010.
REQ-030 Same-cycle conflict (S and M1 open) and M2 invalid for 2nd cycle -> code 01, dir 1001.
REQ-031 While in FAULT assert rst 1 cycle -> STARTUP, all outputs at reset values, normal tracking resumes after 3 cycles.
